// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and widths for the instruction-fetch buffer and its entry FIFO.
package inst_fetch_buffer_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_WAIT = 2'd1,
      IF_DROP = 2'd2
   } if_state_e;

endpackage

// File: rtl/inst_fetch_buffer_fetch_fifo.sv
// Circular FIFO holding fetched {pc, instruction} entries; clear resets occupancy in one cycle.
module inst_fetch_buffer_fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    clear,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;

   // Pointers rely on DEPTH being a power of two to wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: issues one-outstanding word fetches for the PC stream and queues results
// for decode, with flush for branch redirect.
module inst_fetch_buffer
   import inst_fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_ce,
   input  logic [ADDR_W-1:0] pc,
   output logic              stall_req,
   input  logic              flush,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   input  logic              id_ready
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned ENTRY_W = ADDR_W + INST_W;

   if_state_e           state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   req_pc_q;

   logic [PTR_W:0]      count;
   logic [PTR_W+1:0]    occupancy;
   logic [ENTRY_W-1:0]  head;
   logic                busy;
   logic                can_issue;
   logic                accept;
   logic                push;
   logic                pop;

   // The in-flight request holds a reserved slot; a same-cycle pop never frees space.
   assign busy      = (state_q != IF_IDLE);
   assign occupancy = {1'b0, count} + {{(PTR_W + 1){1'b0}}, busy};
   assign can_issue = (state_q == IF_IDLE) || ((state_q == IF_WAIT) && imem_ack);
   assign accept    = pc_ce && !flush && (occupancy < (PTR_W + 2)'(DEPTH)) && can_issue;
   assign stall_req = pc_ce && !flush && !accept;

   assign push = (state_q == IF_WAIT) && imem_ack && !flush;
   assign pop  = id_valid && id_ready && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IF_IDLE;
         addr_q   <= '0;
         req_pc_q <= '0;
      end else begin
         if (accept) begin
            addr_q   <= {pc[ADDR_W-1:2], 2'b00};
            req_pc_q <= pc;
         end
         case (state_q)
            IF_IDLE: begin
               if (accept) state_q <= IF_WAIT;
            end
            IF_WAIT: begin
               // A request is never retracted: a flush without ack waits out the response.
               if (imem_ack)   state_q <= accept ? IF_WAIT : IF_IDLE;
               else if (flush) state_q <= IF_DROP;
            end
            IF_DROP: begin
               if (imem_ack) state_q <= IF_IDLE;
            end
            default: state_q <= IF_IDLE;
         endcase
      end
   end

   inst_fetch_buffer_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fetch_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .wdata ({req_pc_q, imem_rdata}),
      .rdata (head),
      .count (count)
   );

   assign imem_req  = busy;
   assign imem_addr = addr_q;
   assign id_valid  = (count != '0);
   assign id_pc     = head[ENTRY_W-1 -: ADDR_W];
   assign id_inst   = head[INST_W-1:0];

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed per-cycle vector bench for inst_fetch_buffer, plus an asynchronous reset sequence.
module tb_inst_fetch_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_ce;
   logic [31:0] pc;
   logic        stall_req;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_ready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   inst_fetch_buffer #(
      .DEPTH (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_ce      (pc_ce),
      .pc         (pc),
      .stall_req  (stall_req),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .id_inst    (id_inst),
      .id_ready   (id_ready)
   );

   // One record per clock cycle: inputs for the cycle and outputs expected before its edge.
   typedef struct {
      logic        ce;
      logic [31:0] pc;
      logic        fl;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        x_stall;
      logic        x_req;
      logic [31:0] x_addr;
      logic        x_valid;
      logic [31:0] x_pc;
      logic [31:0] x_inst;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t v(input int i_ce, input logic [31:0] i_pc, input int i_fl,
                              input int i_ack, input logic [31:0] i_rdata, input int i_rdy,
                              input int e_stall, input int e_req, input logic [31:0] e_addr,
                              input int e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_inst);
      vec_t r;
      r.ce      = (i_ce != 0);
      r.pc      = i_pc;
      r.fl      = (i_fl != 0);
      r.ack     = (i_ack != 0);
      r.rdata   = i_rdata;
      r.rdy     = (i_rdy != 0);
      r.x_stall = (e_stall != 0);
      r.x_req   = (e_req != 0);
      r.x_addr  = e_addr;
      r.x_valid = (e_valid != 0);
      r.x_pc    = e_pc;
      r.x_inst  = e_inst;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input string name);
      @(negedge clk);
      pc_ce      = t.ce;
      pc         = t.pc;
      flush      = t.fl;
      imem_ack   = t.ack;
      imem_rdata = t.rdata;
      id_ready   = t.rdy;
      #1;
      check({name, ".stall_req"}, 32'(stall_req), 32'(t.x_stall));
      check({name, ".imem_req"}, 32'(imem_req), 32'(t.x_req));
      check({name, ".id_valid"}, 32'(id_valid), 32'(t.x_valid));
      if (t.x_req) check({name, ".imem_addr"}, imem_addr, t.x_addr);
      if (t.x_valid) begin
         check({name, ".id_pc"}, id_pc, t.x_pc);
         check({name, ".id_inst"}, id_inst, t.x_inst);
      end
   endtask

   task automatic run_table(input string tag);
      foreach (tv[i]) apply(tv[i], $sformatf("%s[%0d]", tag, i));
      tv.delete();
   endtask

   task automatic idle_inputs();
      pc_ce      = 1'b0;
      pc         = '0;
      flush      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      id_ready   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.imem_req", 32'(imem_req), 32'h0);
      check("reset.imem_addr", imem_addr, 32'h0);
      check("reset.id_valid", 32'(id_valid), 32'h0);
      check("reset.id_pc", id_pc, 32'h0);
      check("reset.id_inst", id_inst, 32'h0);
      reset = 1'b1;

      // Zero-wait memory, one instruction per cycle.
      tv.push_back(v(1, 32'h0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h4, 0, 1, 32'hA000_0000, 1, 0, 1, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h8, 0, 1, 32'hA000_0004, 1, 0, 1, 32'h4, 1, 32'h0, 32'hA000_0000));
      tv.push_back(v(1, 32'hC, 0, 1, 32'hA000_0008, 1, 0, 1, 32'h8, 1, 32'h4, 32'hA000_0004));
      tv.push_back(v(0, 32'h0, 0, 1, 32'hA000_000C, 1, 0, 1, 32'hC, 1, 32'h8, 32'hA000_0008));
      tv.push_back(v(0, 32'h0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 1, 32'hC, 32'hA000_000C));
      tv.push_back(v(0, 32'h0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
      run_table("zero_wait");

      // Ack two cycles after imem_req rises.
      do_reset();
      tv.push_back(v(1, 32'h0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h4, 0, 0, 32'h0,         1, 1, 1, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h4, 0, 0, 32'h0,         1, 1, 1, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h4, 0, 1, 32'hA000_0000, 1, 0, 1, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h8, 0, 0, 32'h0,         1, 1, 1, 32'h4, 1, 32'h0, 32'hA000_0000));
      tv.push_back(v(1, 32'h8, 0, 0, 32'h0,         1, 1, 1, 32'h4, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h8, 0, 1, 32'hA000_0004, 1, 0, 1, 32'h4, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'hC, 0, 0, 32'h0,         1, 1, 1, 32'h8, 1, 32'h4, 32'hA000_0004));
      tv.push_back(v(1, 32'hC, 0, 0, 32'h0,         1, 1, 1, 32'h8, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'hC, 0, 1, 32'hA000_0008, 1, 0, 1, 32'h8, 0, 32'h0, 32'h0));
      tv.push_back(v(0, 32'h0, 0, 0, 32'h0,         1, 0, 1, 32'hC, 1, 32'h8, 32'hA000_0008));
      run_table("latency3");

      // Fill to DEPTH with decode stalled, then drain and resume.
      do_reset();
      tv.push_back(v(1, 32'h0,  0, 0, 32'h0,         0, 0, 0, 32'h0,  0, 32'h0,  32'h0));
      tv.push_back(v(1, 32'h4,  0, 1, 32'hA000_0000, 0, 0, 1, 32'h0,  0, 32'h0,  32'h0));
      tv.push_back(v(1, 32'h8,  0, 1, 32'hA000_0004, 0, 0, 1, 32'h4,  1, 32'h0,  32'hA000_0000));
      tv.push_back(v(1, 32'hC,  0, 1, 32'hA000_0008, 0, 0, 1, 32'h8,  1, 32'h0,  32'hA000_0000));
      tv.push_back(v(1, 32'h10, 0, 1, 32'hA000_000C, 0, 1, 1, 32'hC,  1, 32'h0,  32'hA000_0000));
      tv.push_back(v(1, 32'h10, 0, 0, 32'h0,         0, 1, 0, 32'h0,  1, 32'h0,  32'hA000_0000));
      tv.push_back(v(1, 32'h10, 0, 0, 32'h0,         1, 1, 0, 32'h0,  1, 32'h0,  32'hA000_0000));
      tv.push_back(v(1, 32'h10, 0, 0, 32'h0,         1, 0, 0, 32'h0,  1, 32'h4,  32'hA000_0004));
      tv.push_back(v(1, 32'h14, 0, 1, 32'hA000_0010, 1, 0, 1, 32'h10, 1, 32'h8,  32'hA000_0008));
      tv.push_back(v(0, 32'h0,  0, 1, 32'hA000_0014, 1, 0, 1, 32'h14, 1, 32'hC,  32'hA000_000C));
      tv.push_back(v(0, 32'h0,  0, 0, 32'h0,         1, 0, 0, 32'h0,  1, 32'h10, 32'hA000_0010));
      tv.push_back(v(0, 32'h0,  0, 0, 32'h0,         1, 0, 0, 32'h0,  1, 32'h14, 32'hA000_0014));
      tv.push_back(v(0, 32'h0,  0, 0, 32'h0,         1, 0, 0, 32'h0,  0, 32'h0,  32'h0));
      run_table("full");

      // Flush in IF_WAIT without ack: response dropped, redirect to 0x400.
      do_reset();
      tv.push_back(v(1, 32'h0,   0, 0, 32'h0,         0, 0, 0, 32'h0,   0, 32'h0,   32'h0));
      tv.push_back(v(1, 32'h4,   0, 1, 32'hA000_0000, 0, 0, 1, 32'h0,   0, 32'h0,   32'h0));
      tv.push_back(v(1, 32'h8,   1, 0, 32'h0,         0, 0, 1, 32'h4,   1, 32'h0,   32'hA000_0000));
      tv.push_back(v(1, 32'h400, 0, 0, 32'h0,         0, 1, 1, 32'h4,   0, 32'h0,   32'h0));
      tv.push_back(v(1, 32'h400, 0, 1, 32'hDEAD_BEEF, 0, 1, 1, 32'h4,   0, 32'h0,   32'h0));
      tv.push_back(v(1, 32'h400, 0, 0, 32'h0,         0, 0, 0, 32'h0,   0, 32'h0,   32'h0));
      tv.push_back(v(0, 32'h0,   0, 1, 32'hA000_0400, 0, 0, 1, 32'h400, 0, 32'h0,   32'h0));
      tv.push_back(v(0, 32'h0,   0, 0, 32'h0,         1, 0, 0, 32'h0,   1, 32'h400, 32'hA000_0400));
      tv.push_back(v(0, 32'h0,   0, 0, 32'h0,         1, 0, 0, 32'h0,   0, 32'h0,   32'h0));
      run_table("flush_wait");

      // Flush coinciding with ack: data discarded, straight back to IF_IDLE.
      do_reset();
      tv.push_back(v(1, 32'h0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h4, 1, 1, 32'hBAD0_BAD0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h8, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(0, 32'h0, 0, 1, 32'hA000_0008, 1, 0, 1, 32'h8, 0, 32'h0, 32'h0));
      tv.push_back(v(0, 32'h0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h8, 32'hA000_0008));
      run_table("flush_ack");

      // Asynchronous reset between clock edges while a request is outstanding.
      do_reset();
      tv.push_back(v(1, 32'h0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
      tv.push_back(v(1, 32'h4, 0, 1, 32'hA000_0000, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0));
      run_table("async_pre");
      @(negedge clk);
      idle_inputs();
      #1;
      check("async.req_before", 32'(imem_req), 32'h1);
      check("async.valid_before", 32'(id_valid), 32'h1);
      reset = 1'b0;
      #1;
      check("async.imem_req", 32'(imem_req), 32'h0);
      check("async.id_valid", 32'(id_valid), 32'h0);
      check("async.imem_addr", imem_addr, 32'h0);
      check("async.id_pc", id_pc, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tv.push_back(v(1, 32'h80, 0, 0, 32'h0,         0, 0, 0, 32'h0,  0, 32'h0,  32'h0));
      tv.push_back(v(0, 32'h0,  0, 1, 32'hA000_0080, 0, 0, 1, 32'h80, 0, 32'h0,  32'h0));
      tv.push_back(v(0, 32'h0,  0, 0, 32'h0,         1, 0, 0, 32'h0,  1, 32'h80, 32'hA000_0080));
      tv.push_back(v(0, 32'h0,  0, 0, 32'h0,         1, 0, 0, 32'h0,  0, 32'h0,  32'h0));
      run_table("async_post");

      // Unaligned PC: address is word-aligned, the entry keeps the original PC.
      do_reset();
      tv.push_back(v(1, 32'h1002, 0, 0, 32'h0,         1, 0, 0, 32'h0,    0, 32'h0,    32'h0));
      tv.push_back(v(0, 32'h0,    0, 1, 32'h1234_5678, 1, 0, 1, 32'h1000, 0, 32'h0,    32'h0));
      tv.push_back(v(0, 32'h0,    0, 0, 32'h0,         1, 0, 0, 32'h0,    1, 32'h1002, 32'h1234_5678));
      tv.push_back(v(0, 32'h0,    0, 0, 32'h0,         1, 0, 0, 32'h0,    0, 32'h0,    32'h0));
      run_table("unaligned");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
